geofence_alarm: RTL
===================

# geofence_alarm

Downstream consumer of the geofence classifier. Takes the one-cycle `valid`/`is_inside` result pulse produced once per object frame and keeps a sliding window of the last WIN results. It raises a hysteretic intrusion alarm from the count of "outside" verdicts in that window, and maintains saturating lifetime counters for software readout. Purely sequential bookkeeping: no back-pressure is applied to the classifier, and every result pulse is consumed.

## Interface
- WIN, 8, window depth in results; legal 2..16.
- ENTER_TH, 6, outside-count at or above which the alarm sets; EXIT_TH < ENTER_TH <= WIN.
- EXIT_TH, 2, outside-count at or below which the alarm clears.
- CNT_W, 16, width of lifetime counters.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- valid  in  1  result strobe from classifier; any cycle, back-to-back legal.
- is_inside  in  1  verdict, meaningful only when valid=1; 0 = outside.
- clear  in  1  synchronous flush of window, counters and alarm.
- win_full  out  1  window holds WIN results.
- out_cnt  out  $clog2(WIN+1)  outside verdicts currently in window.
- alarm  out  1  alarm level.
- alarm_set  out  1  one-cycle pulse on alarm 0->1.
- alarm_clr  out  1  one-cycle pulse on alarm 1->0.
- total_cnt  out  CNT_W  results accepted since reset/clear, saturating.
- inside_cnt  out  CNT_W  inside results accepted, saturating.

## Operation
- Window: WIN-bit shift register `hist`, bit 1 = outside. A fill counter `fill` runs 0..WIN.
- Accept (valid=1, clear=0):
  - Shift `~is_inside` into hist[0]; the oldest bit is hist[WIN-1].
  - out_cnt_next = out_cnt + ~is_inside − (win_full ? hist[WIN-1] : 0).
  - fill increments, saturating at WIN.
  - total_cnt increments; inside_cnt increments if is_inside. Both hold at all-ones.
- State machine (transitions evaluated only on accept cycles, using out_cnt_next and fill_next):
  - FILL: alarm=0. When fill_next==WIN, go to ALARM if out_cnt_next>=ENTER_TH, else MONITOR. Otherwise stay.
  - MONITOR: alarm=0. Go to ALARM if out_cnt_next>=ENTER_TH.
  - ALARM: alarm=1. Go to MONITOR if out_cnt_next<=EXIT_TH. Counts strictly between the thresholds hold the current state.
- alarm_set fires on entry to ALARM; alarm_clr fires on exit from ALARM, including exit by clear.
- clear=1:
  - hist, fill, out_cnt, total_cnt and inside_cnt go to 0; state goes to FILL.
  - If the state was ALARM, alarm_clr pulses.
  - Any simultaneous valid is dropped, not counted.
- win_full = (fill==WIN). Once full, it stays 1 until reset or clear.
- No X-propagation: is_inside is ignored when valid=0.

## Timing
- Reset values: all outputs 0, state FILL, hist 0, fill 0.
- Reset asserted mid-operation forces the reset values immediately; no pulse is emitted.
- All outputs are registered. A result sampled at edge k is reflected in out_cnt, win_full, counters, alarm and pulses after edge k (visible during cycle k+1). Latency is 1 cycle.
- alarm_set and alarm_clr are high for exactly one cycle and are never high together.
- Back-to-back valids are each processed with 1-cycle latency; throughput is 1 result/cycle.

## Test plan
- Reset, then 7 outside results: win_full=0, out_cnt=7, alarm=0. 8th outside: win_full=1, out_cnt=8, alarm=1, alarm_set one cycle after the 8th valid.
- Fill with 8 inside results, then 6 outside: alarm sets on the 6th outside (out_cnt=6), with exactly one alarm_set pulse.
- From alarm with out_cnt=8, feed inside results: out_cnt goes 7,6,5,4,3 with alarm held. The 6th inside gives out_cnt=2, alarm=0, and one alarm_clr pulse.
- Hysteresis: from MONITOR, oscillate out_cnt between 3 and 5 → alarm never sets. From ALARM, the same oscillation → alarm never clears.
- clear asserted in ALARM together with valid: the next cycle shows all counters 0, win_full=0, alarm=0, alarm_clr=1, and total_cnt stays 0.
- Saturation with CNT_W=4: 20 inside valids → total_cnt=15, inside_cnt=15, and the window still behaves correctly.

Source files
------------

// File: rtl/geofence_alarm.sv
// geofence_alarm: sliding-window intrusion alarm fed by the geofence classifier.
// Keeps the last WIN verdicts (bit 1 = outside) and raises a hysteretic alarm
// from the count of outside verdicts. It also keeps saturating lifetime counters.
// Ports:
//   clk, reset (async, active-high)
//   valid, is_inside   - one-cycle result strobe and its verdict
//   clear              - synchronous flush of window, counters and alarm
//   win_full, out_cnt  - window status
//   alarm, alarm_set, alarm_clr - alarm level and its edge pulses
//   total_cnt, inside_cnt       - saturating lifetime counters
module geofence_alarm #(
  parameter int unsigned WIN      = 8,
  parameter int unsigned ENTER_TH = 6,
  parameter int unsigned EXIT_TH  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic                       is_inside,
  input  logic                       clear,
  output logic                       win_full,
  output logic [$clog2(WIN+1)-1:0]   out_cnt,
  output logic                       alarm,
  output logic                       alarm_set,
  output logic                       alarm_clr,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [CNT_W-1:0]           inside_cnt
);

  localparam int unsigned CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] WIN_C   = CW'(WIN);
  localparam logic [CW-1:0] ENTER_C = CW'(ENTER_TH);
  localparam logic [CW-1:0] EXIT_C  = CW'(EXIT_TH);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_ALARM   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WIN-1:0] hist;
  logic [CW-1:0]  fill;
  logic [CW-1:0]  fill_next;
  logic [CW-1:0]  out_cnt_next;
  logic           outside;
  logic           drop_oldest;

  // Prospective window count, fill level and state for an accepted result
  always_comb begin
    outside      = ~is_inside;
    drop_oldest  = win_full & hist[WIN-1];
    // Modular add/sub: out_cnt never exceeds WIN once the oldest bit is retired
    out_cnt_next = out_cnt + CW'(outside) - CW'(drop_oldest);
    fill_next    = (fill == WIN_C) ? fill : fill + CW'(1);
    state_next   = state;
    case (state)
      ST_FILL: begin
        if (fill_next == WIN_C)
          state_next = (out_cnt_next >= ENTER_C) ? ST_ALARM : ST_MONITOR;
      end
      ST_MONITOR: begin
        if (out_cnt_next >= ENTER_C) state_next = ST_ALARM;
      end
      ST_ALARM: begin
        if (out_cnt_next <= EXIT_C) state_next = ST_MONITOR;
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Window, counters, state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      hist       <= '0;
      fill       <= '0;
      out_cnt    <= '0;
      win_full   <= 1'b0;
      alarm      <= 1'b0;
      alarm_set  <= 1'b0;
      alarm_clr  <= 1'b0;
      total_cnt  <= '0;
      inside_cnt <= '0;
    end else begin
      alarm_set <= 1'b0;
      alarm_clr <= 1'b0;
      if (clear) begin
        // A simultaneous valid is dropped
        state      <= ST_FILL;
        hist       <= '0;
        fill       <= '0;
        out_cnt    <= '0;
        win_full   <= 1'b0;
        alarm      <= 1'b0;
        alarm_clr  <= (state == ST_ALARM);
        total_cnt  <= '0;
        inside_cnt <= '0;
      end else if (valid) begin
        hist     <= {hist[WIN-2:0], outside};
        fill     <= fill_next;
        out_cnt  <= out_cnt_next;
        win_full <= (fill_next == WIN_C);
        state    <= state_next;
        alarm    <= (state_next == ST_ALARM);
        alarm_set <= (state_next == ST_ALARM) && (state != ST_ALARM);
        alarm_clr <= (state == ST_ALARM) && (state_next != ST_ALARM);
        if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
        if (is_inside && (inside_cnt != '1)) inside_cnt <= inside_cnt + CNT_W'(1);
      end
    end
  end

endmodule
